vga_scan_driver: RTL and testbench

VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

---
 rtl/vga_scan_driver.sv | 154 +++++++++++++++
 tb/tb_vga_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_driver.sv
// VGA raster scan generator: pixel-rate divider, h/v scan counters, sync and
// enable decode, a renderer-latency matching delay line and registered
// pixel outputs.
module vga_scan_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    input  logic [7:0] color_in,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] div_q, div_d;
    logic       tick_q, tick_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       h_wrap;

    // Control bits are carried as {in_hsync, in_vsync, active} so an all-zero
    // stage reads as blanked; the sync polarity flip happens at the output.
    logic [2:0] ctrl_raw;
    logic [2:0] ctrl_dly;
    logic       active_raw;

    logic       hsync_q, vsync_q, de_q;
    logic [7:0] rgb_q;

    // Divider next state; the strobe is registered so it is low in reset.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 2'd1;
        tick_d = (div_q == DIV_LAST);
    end

    // Pixel-rate divider and registered pix_tick strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // Scan counter next state: vcount steps only when hcount wraps.
    always_comb begin
        h_wrap   = (hcount_q == H_LAST);
        hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
    end

    // Horizontal and vertical scan counters, advanced once per pixel tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (tick_q) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Undelayed decode of the current scan position.
    always_comb begin
        active_raw  = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        ctrl_raw    = {(hcount_q >= HS_FIRST) && (hcount_q < HS_END),
                       (vcount_q >= VS_FIRST) && (vcount_q < VS_END),
                       active_raw};
        xpos        = active_raw ? hcount_q : '0;
        ypos        = active_raw ? vcount_q : '0;
        frame_start = tick_q && (hcount_q == '0) && (vcount_q == '0);
    end

    // Delay line matching the renderer latency; zero stages is a pass-through.
    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign ctrl_dly = ctrl_raw;
        end else begin : g_pipe
            logic [3*PIPE_LAT-1:0] pipe_q, pipe_d;
            if (PIPE_LAT == 1) begin : g_one
                assign pipe_d = ctrl_raw;
            end else begin : g_many
                assign pipe_d = {pipe_q[3*PIPE_LAT-4:0], ctrl_raw};
            end
            // Shift one position per pixel tick.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (tick_q) begin
                    pipe_q <= pipe_d;
                end
            end
            assign ctrl_dly = pipe_q[3*PIPE_LAT-1 -: 3];
        end
    endgenerate

    // Output register: delayed controls and renderer color leave together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (tick_q) begin
            hsync_q <= ~ctrl_dly[2];
            vsync_q <= ~ctrl_dly[1];
            de_q    <= ctrl_dly[0];
            rgb_q   <= ctrl_dly[0] ? color_in : '0;
        end
    end

    assign pix_tick = tick_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign vga_r    = rgb_q[7:5];
    assign vga_g    = rgb_q[4:2];
    assign vga_b    = rgb_q[1:0];

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver using a shrunken raster (24x13 totals)
// so whole frames fit in a short run. Instance a: CLK_DIV=2, PIPE_LAT=1.
// Instance b: CLK_DIV=1, PIPE_LAT=0.
module tb_vga_scan_driver;

    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 2;
    localparam int unsigned HS  = 3;
    localparam int unsigned HBP = 3;
    localparam int unsigned HT  = 24;
    localparam int unsigned VA  = 8;
    localparam int unsigned VFP = 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 2;
    localparam int unsigned VT  = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] color_a, color_b;
    logic [9:0] xpos_a, ypos_a, xpos_b, ypos_b;
    logic       tick_a, fs_a, hs_a, vs_a, de_a;
    logic       tick_b, fs_b, hs_b, vs_b, de_b;
    logic [2:0] r_a, g_a, r_b, g_b;
    logic [1:0] b_a, b_b;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned kclk        = 0;

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(2), .PIPE_LAT(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .xpos(xpos_a), .ypos(ypos_a),
        .color_in(color_a), .pix_tick(tick_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(1), .PIPE_LAT(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .xpos(xpos_b), .ypos(ypos_b),
        .color_in(color_b), .pix_tick(tick_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    function automatic logic [7:0] colorf(input int unsigned h, input int unsigned v);
        logic [9:0] x, y;
        x = h[9:0];
        y = v[9:0];
        return {x[2:0], y[2:0], x[1:0]};
    endfunction

    // Renderer color for tick-position t: pattern when visible, all-ones in blanking.
    function automatic logic [7:0] render(input int t);
        int unsigned h, v;
        if (t < 0) return 8'hFF;
        h = int'(t) % HT;
        v = (int'(t) / HT) % VT;
        return (h < HA && v < VA) ? colorf(h, v) : 8'hFF;
    endfunction

    // One clock of instance sel: compare all outputs against the raster model
    // indexed by clocks since reset release, then drive the renderer color.
    task automatic scan_cycle(input bit sel);
        int unsigned d, l, t, h, v, sh, sv;
        int          s;
        bit          tick_e, fs_e, hs_e, vs_e, de_e, act;
        logic [7:0]  rgb_e, rgb_o;
        logic [9:0]  x_e, y_e, x_o, y_o;
        logic        tick_o, fs_o, hs_o, vs_o, de_o;
        string       dn;
        @(negedge clk);
        kclk++;
        d  = sel ? 1 : 2;
        l  = sel ? 0 : 1;
        dn = sel ? "b" : "a";
        tick_e = (kclk % d) == 0;
        t = (kclk - 1) / d;
        h = t % HT;
        v = (t / HT) % VT;
        act  = (h < HA) && (v < VA);
        x_e  = act ? h[9:0] : 10'd0;
        y_e  = act ? v[9:0] : 10'd0;
        fs_e = tick_e && h == 0 && v == 0;
        s = int'(t) - int'(l) - 1;
        if (s < 0) begin
            hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0; rgb_e = 8'h00;
        end else begin
            sh = s % HT;
            sv = (s / HT) % VT;
            hs_e  = !(sh >= HA + HFP && sh < HA + HFP + HS);
            vs_e  = !(sv >= VA + VFP && sv < VA + VFP + VS);
            de_e  = (sh < HA) && (sv < VA);
            rgb_e = de_e ? colorf(sh, sv) : 8'h00;
        end
        tick_o = sel ? tick_b : tick_a;
        fs_o   = sel ? fs_b : fs_a;
        hs_o   = sel ? hs_b : hs_a;
        vs_o   = sel ? vs_b : vs_a;
        de_o   = sel ? de_b : de_a;
        x_o    = sel ? xpos_b : xpos_a;
        y_o    = sel ? ypos_b : ypos_a;
        rgb_o  = sel ? {r_b, g_b, b_b} : {r_a, g_a, b_a};
        vectors += 8;
        if (tick_o !== tick_e) begin miscompares++; $display("FAIL pix_tick_%s k=%0d got %b want %b", dn, kclk, tick_o, tick_e); end
        if (fs_o !== fs_e) begin miscompares++; $display("FAIL frame_start_%s k=%0d got %b want %b", dn, kclk, fs_o, fs_e); end
        if (x_o !== x_e) begin miscompares++; $display("FAIL xpos_%s k=%0d got %0d want %0d", dn, kclk, x_o, x_e); end
        if (y_o !== y_e) begin miscompares++; $display("FAIL ypos_%s k=%0d got %0d want %0d", dn, kclk, y_o, y_e); end
        if (hs_o !== hs_e) begin miscompares++; $display("FAIL hsync_%s k=%0d got %b want %b", dn, kclk, hs_o, hs_e); end
        if (vs_o !== vs_e) begin miscompares++; $display("FAIL vsync_%s k=%0d got %b want %b", dn, kclk, vs_o, vs_e); end
        if (de_o !== de_e) begin miscompares++; $display("FAIL de_%s k=%0d got %b want %b", dn, kclk, de_o, de_e); end
        if (rgb_o !== rgb_e) begin miscompares++; $display("FAIL rgb_%s k=%0d got %h want %h", dn, kclk, rgb_o, rgb_e); end
        if (sel) color_b = render(int'(t) - int'(l));
        else     color_a = render(int'(t) - int'(l));
    endtask

    task automatic test_reset();
        logic [32:0] exp_v, obs_a, obs_b;
        rst_a = 1'b1; rst_b = 1'b1;
        color_a = 8'hFF; color_b = 8'hFF;
        repeat (3) @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0};
        obs_a = {tick_a, fs_a, hs_a, vs_a, de_a, r_a, g_a, b_a, xpos_a, ypos_a};
        obs_b = {tick_b, fs_b, hs_b, vs_b, de_b, r_b, g_b, b_b, xpos_b, ypos_b};
        vectors += 2;
        if (obs_a !== exp_v) begin miscompares++; $display("FAIL reset_a got %h want %h", obs_a, exp_v); end
        if (obs_b !== exp_v) begin miscompares++; $display("FAIL reset_b got %h want %h", obs_b, exp_v); end
    endtask

    task automatic test_frame_a();
        int unsigned nfs, k1, k2, ticks, hs_falls, hs_low, vs_low, de_ticks;
        bit hs_prev;
        nfs = 0; k1 = 0; k2 = 0; ticks = 0; hs_falls = 0; hs_low = 0; vs_low = 0; de_ticks = 0;
        hs_prev = 1'b1;
        color_a = 8'hFF;
        rst_a = 1'b0;
        kclk = 0;
        for (int i = 0; i < 1300; i++) begin
            scan_cycle(1'b0);
            if (fs_a === 1'b1) begin
                nfs++;
                if (nfs == 1) k1 = kclk;
                if (nfs == 2) k2 = kclk;
            end
            if (nfs == 1) begin
                if (tick_a === 1'b1) ticks++;
                if (hs_a === 1'b0 && hs_prev) hs_falls++;
                if (hs_a === 1'b0) hs_low++;
                if (vs_a === 1'b0) vs_low++;
                if (de_a === 1'b1 && tick_a === 1'b1) de_ticks++;
            end
            hs_prev = (hs_a !== 1'b0);
        end
        vectors += 7;
        if (k1 !== 2) begin miscompares++; $display("FAIL first_frame_start_a k got %0d want 2", k1); end
        if (k2 - k1 !== 624) begin miscompares++; $display("FAIL frame_period_a clocks got %0d want 624", k2 - k1); end
        if (ticks !== 312) begin miscompares++; $display("FAIL ticks_per_frame_a got %0d want 312", ticks); end
        if (hs_falls !== 13) begin miscompares++; $display("FAIL hsync_pulses_a got %0d want 13", hs_falls); end
        if (hs_low !== 78) begin miscompares++; $display("FAIL hsync_low_clocks_a got %0d want 78", hs_low); end
        if (vs_low !== 96) begin miscompares++; $display("FAIL vsync_low_clocks_a got %0d want 96", vs_low); end
        if (de_ticks !== 128) begin miscompares++; $display("FAIL de_ticks_a got %0d want 128", de_ticks); end
    endtask

    task automatic test_midframe_reset();
        bit          hit;
        int unsigned first_fs, first_hs;
        logic [32:0] exp_v, obs_a;
        hit = 1'b0;
        for (int i = 0; i < 1400 && !hit; i++) begin
            scan_cycle(1'b0);
            if (((kclk - 1) / 2) % (HT * VT) == 5 * HT + 10) hit = 1'b1;
        end
        vectors++;
        if (!hit || xpos_a !== 10'd10 || ypos_a !== 10'd5) begin
            miscompares++;
            $display("FAIL reach_10_5_a got x=%0d y=%0d want x=10 y=5", xpos_a, ypos_a);
        end
        #1 rst_a = 1'b1;
        #1;
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 10'd0, 10'd0};
        obs_a = {tick_a, fs_a, hs_a, vs_a, de_a, r_a, g_a, b_a, xpos_a, ypos_a};
        vectors++;
        if (obs_a !== exp_v) begin miscompares++; $display("FAIL async_reset_a got %h want %h", obs_a, exp_v); end
        repeat (3) @(negedge clk);
        color_a = 8'hFF;
        rst_a = 1'b0;
        kclk = 0;
        first_fs = 0; first_hs = 0;
        for (int i = 0; i < 60; i++) begin
            scan_cycle(1'b0);
            if (fs_a === 1'b1 && first_fs == 0) first_fs = kclk;
            if (hs_a === 1'b0 && first_hs == 0) first_hs = kclk;
        end
        vectors += 2;
        if (first_fs !== 2) begin miscompares++; $display("FAIL restart_frame_start_a k got %0d want 2", first_fs); end
        if (first_hs !== 41) begin miscompares++; $display("FAIL restart_hsync_fall_a k got %0d want 41", first_hs); end
    endtask

    task automatic test_fast_b();
        int unsigned nfs, k1, k2, ticks;
        nfs = 0; k1 = 0; k2 = 0; ticks = 0;
        rst_a = 1'b1;
        color_b = render(0);
        rst_b = 1'b0;
        kclk = 0;
        for (int i = 0; i < 640; i++) begin
            scan_cycle(1'b1);
            if (fs_b === 1'b1) begin
                nfs++;
                if (nfs == 1) k1 = kclk;
                if (nfs == 2) k2 = kclk;
            end
            if (nfs == 1 && tick_b === 1'b1) ticks++;
        end
        vectors += 3;
        if (k1 !== 1) begin miscompares++; $display("FAIL first_frame_start_b k got %0d want 1", k1); end
        if (k2 - k1 !== 312) begin miscompares++; $display("FAIL frame_period_b clocks got %0d want 312", k2 - k1); end
        if (ticks !== 312) begin miscompares++; $display("FAIL ticks_per_frame_b got %0d want 312", ticks); end
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_midframe_reset();
        test_fast_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
